// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 device-to-host frame receiver with status/data word
//
// Purpose:
//    Deserialises 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop)
//    and holds the last good scancode in a status/data word for the CPU. The
//    CPU acknowledges the word with a one-cycle ps2_read_ack pulse, which clears
//    valid, overrun and parity_err. Receive-only: the PS/2 lines are never driven.
//
// Ports:
//    clk           system clock, all state on the rising edge
//    reset_n       asynchronous active-low reset
//    ps2_clk       raw PS/2 clock from the device (asynchronous)
//    ps2_data      raw PS/2 data from the device (asynchronous)
//    ps2_read_ack  high for one cycle when the CPU acknowledges the word
//    ps2_read      {zeros, parity_err, overrun, valid, scancode[7:0]}

module ps2_receiver #(
   parameter int N       = 32,
   parameter int TIMEOUT = 50000
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   input  logic         ps2_read_ack,
   output logic [N-1:0] ps2_read
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // Synchronisers; clk_prev is one more stage so a falling edge can be seen.
   logic clk_meta_q, clk_meta_d;
   logic clk_sync_q, clk_sync_d;
   logic clk_prev_q, clk_prev_d;
   logic dat_meta_q, dat_meta_d;
   logic dat_sync_q, dat_sync_d;

   // Frame deserialiser
   state_t          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic [CW-1:0]   to_cnt_q, to_cnt_d;

   // CPU-visible word
   logic [7:0]      scancode_q, scancode_d;
   logic            valid_q, valid_d;
   logic            overrun_q, overrun_d;
   logic            parity_err_q, parity_err_d;

   logic            fall;
   logic            done;
   logic            frame_ok;

   assign fall     = clk_prev_q & ~clk_sync_q;
   assign done     = fall && (state_q == ST_STOP);
   // Odd parity over data+parity, and the stop bit being sampled right now must be 1.
   assign frame_ok = dat_sync_q & (^{shift_q, parity_q});

   always_comb begin
      clk_meta_d = ps2_clk;
      clk_sync_d = clk_meta_q;
      clk_prev_d = clk_sync_q;
      dat_meta_d = ps2_data;
      dat_sync_d = dat_meta_q;
   end

   // Frame FSM: one transition per PS/2 falling edge, plus the inactivity timeout.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      to_cnt_d  = to_cnt_q;

      case (state_q)
         ST_IDLE: begin
            // A high data bit on a fall is not a start bit; ignore it.
            if (fall && !dat_sync_q) begin
               state_d   = ST_DATA;
               bit_cnt_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (fall) begin
               shift_d[bit_cnt_q] = dat_sync_q;
               bit_cnt_d          = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (fall) begin
               parity_d = dat_sync_q;
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A fall in the same cycle as expiry wins: the device is still talking.
      if (state_q == ST_IDLE) begin
         to_cnt_d = '0;
      end else if (fall) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
         to_cnt_d  = '0;
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
      end else begin
         to_cnt_d = to_cnt_q + CW'(1);
      end
   end

   // Status word: ack clears flags first, then a completing frame is applied on top.
   always_comb begin
      scancode_d   = scancode_q;
      valid_d      = valid_q;
      overrun_d    = overrun_q;
      parity_err_d = parity_err_q;

      if (ps2_read_ack) begin
         valid_d      = 1'b0;
         overrun_d    = 1'b0;
         parity_err_d = 1'b0;
      end

      if (done) begin
         if (frame_ok) begin
            // valid_d already reflects a same-cycle ack, so an acked byte is replaced.
            if (!valid_d) begin
               scancode_d   = shift_q;
               valid_d      = 1'b1;
               parity_err_d = 1'b0;
            end else begin
               overrun_d = 1'b1;
            end
         end else begin
            parity_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q   <= 1'b1;
         clk_sync_q   <= 1'b1;
         clk_prev_q   <= 1'b1;
         dat_meta_q   <= 1'b1;
         dat_sync_q   <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         parity_q     <= 1'b0;
         to_cnt_q     <= '0;
         scancode_q   <= 8'd0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         clk_meta_q   <= clk_meta_d;
         clk_sync_q   <= clk_sync_d;
         clk_prev_q   <= clk_prev_d;
         dat_meta_q   <= dat_meta_d;
         dat_sync_q   <= dat_sync_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         to_cnt_q     <= to_cnt_d;
         scancode_q   <= scancode_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign ps2_read = {{(N - 11){1'b0}}, parity_err_q, overrun_q, valid_q, scancode_q};

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - self-checking bench for ps2_receiver

module tb_ps2_receiver;

   localparam int N       = 32;
   localparam int TIMEOUT = 200;
   localparam int HALF    = 20;   // PS/2 half-period in system clocks

   logic          clk;
   logic          reset_n;
   logic          ps2_clk;
   logic          ps2_data;
   logic          ps2_read_ack;
   logic [N-1:0]  ps2_read;

   int vectors;
   int miscompares;

   // Reference model of the CPU-visible word
   logic [7:0] m_scan;
   bit         m_valid;
   bit         m_ovr;
   bit         m_perr;

   typedef struct {
      bit          rst;
      logic [7:0]  b;
      bit          par_bad;
      bit          stop_bad;
      logic [31:0] exp;
      bit          do_ack;
      logic [31:0] exp_ack;
   } vec_t;

   vec_t tbl[12];

   ps2_receiver #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .ps2_read_ack (ps2_read_ack),
      .ps2_read     (ps2_read)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_word();
      return {21'd0, m_perr, m_ovr, m_valid, m_scan};
   endfunction

   function automatic void model_clear();
      m_scan  = 8'd0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
   endfunction

   function automatic void model_ack();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
   endfunction

   function automatic void model_frame(input logic [7:0] b, input logic par,
                                       input logic stop, input bit ack);
      bit ok;
      ok = (stop == 1'b1) && ((($countones(b) + int'(par)) % 2) == 1);
      if (ack) model_ack();
      if (ok) begin
         if (!m_valid) begin
            m_scan  = b;
            m_valid = 1'b1;
            m_perr  = 1'b0;
         end else begin
            m_ovr = 1'b1;
         end
      end else begin
         m_perr = 1'b1;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n      = 1'b0;
      ps2_clk      = 1'b1;
      ps2_data     = 1'b1;
      ps2_read_ack = 1'b0;
      wait_cyc(3);
      reset_n = 1'b1;
      wait_cyc(2);
      model_clear();
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      ps2_read_ack = 1'b1;
      @(negedge clk);
      ps2_read_ack = 1'b0;
      wait_cyc(1);
      model_ack();
   endtask

   // Sends the first nbits of a frame. With ack_at_stop the ack is timed to the
   // cycle in which the stop-bit fall is seen after the two-flop synchroniser.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                             input int nbits, input bit ack_at_stop);
      logic [10:0] bits;
      bits = {stop, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         if (i == 10 && ack_at_stop) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            ps2_read_ack = 1'b1;
            @(negedge clk);
            ps2_read_ack = 1'b0;
            wait_cyc(HALF - 2);
         end else begin
            wait_cyc(HALF);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cyc(HALF);
   endtask

   initial begin
      logic [7:0] b;
      logic       par;
      logic       stop;
      int         r;
      bit         coinc;
      bit         dack;

      vectors      = 0;
      miscompares  = 0;
      reset_n      = 1'b0;
      ps2_clk      = 1'b1;
      ps2_data     = 1'b1;
      ps2_read_ack = 1'b0;
      model_clear();

      tbl[0]  = '{1'b1, 8'h1C, 1'b0, 1'b0, 32'h0000011C, 1'b1, 32'h0000001C};
      tbl[1]  = '{1'b1, 8'h1C, 1'b1, 1'b0, 32'h00000400, 1'b1, 32'h00000000};
      tbl[2]  = '{1'b1, 8'h1C, 1'b0, 1'b0, 32'h0000011C, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 8'h32, 1'b0, 1'b0, 32'h0000031C, 1'b1, 32'h0000001C};
      tbl[4]  = '{1'b0, 8'h55, 1'b0, 1'b1, 32'h0000041C, 1'b1, 32'h0000001C};
      tbl[5]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 32'h000001A5, 1'b0, 32'h0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h000005A5, 1'b1, 32'h000000A5};
      tbl[7]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 32'h000001FF, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 8'h12, 1'b0, 1'b0, 32'h000003FF, 1'b0, 32'h0};
      tbl[9]  = '{1'b0, 8'h34, 1'b1, 1'b0, 32'h000007FF, 1'b1, 32'h000000FF};
      tbl[10] = '{1'b0, 8'h5A, 1'b1, 1'b0, 32'h000004FF, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 8'h5A, 1'b0, 1'b0, 32'h0000015A, 1'b0, 32'h0};

      wait_cyc(3);
      check("reset_value", ps2_read, 32'h0);
      reset_n = 1'b1;
      wait_cyc(2);

      // Directed table
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].rst) do_reset();
         par  = (~^tbl[i].b) ^ tbl[i].par_bad;
         stop = ~tbl[i].stop_bad;
         send_frame(tbl[i].b, par, stop, 11, 1'b0);
         model_frame(tbl[i].b, par, stop, 1'b0);
         wait_cyc(2);
         check($sformatf("table%0d_frame", i), ps2_read, tbl[i].exp);
         if (tbl[i].do_ack) begin
            ack_pulse();
            check($sformatf("table%0d_ack", i), ps2_read, tbl[i].exp_ack);
         end
      end

      // Ack coincident with a good completion while a byte is pending
      do_reset();
      send_frame(8'h1C, ~^8'h1C, 1'b1, 11, 1'b0);
      model_frame(8'h1C, ~^8'h1C, 1'b1, 1'b0);
      send_frame(8'h32, ~^8'h32, 1'b1, 11, 1'b1);
      model_frame(8'h32, ~^8'h32, 1'b1, 1'b1);
      wait_cyc(2);
      check("coincident_ack", ps2_read, 32'h00000132);

      // Partial frame abandoned by the timeout, then a full frame
      do_reset();
      send_frame(8'h0F, 1'b0, 1'b1, 5, 1'b0);
      wait_cyc(TIMEOUT + 50);
      check("timeout_no_flags", ps2_read, 32'h0);
      send_frame(8'hF0, ~^8'hF0, 1'b1, 11, 1'b0);
      model_frame(8'hF0, ~^8'hF0, 1'b1, 1'b0);
      wait_cyc(2);
      check("after_timeout", ps2_read, 32'h000001F0);

      // Reset in the middle of a frame
      send_frame(8'h1C, ~^8'h1C, 1'b1, 11, 1'b0);   // leaves overrun set
      send_frame(8'h77, 1'b0, 1'b1, 5, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      wait_cyc(2);
      check("during_reset", ps2_read, 32'h0);
      wait_cyc(2);
      reset_n = 1'b1;
      model_clear();
      wait_cyc(2);
      send_frame(8'h1C, ~^8'h1C, 1'b1, 11, 1'b0);
      model_frame(8'h1C, ~^8'h1C, 1'b1, 1'b0);
      wait_cyc(2);
      check("after_mid_reset", ps2_read, 32'h0000011C);

      // Randomised frames against the model
      for (int i = 0; i < 30; i++) begin
         b     = 8'($urandom);
         r     = int'($urandom_range(0, 7));
         par   = (~^b) ^ ((r == 0) || (r == 1));
         stop  = (r != 2);
         coinc = (r == 3);
         dack  = ($urandom_range(0, 1) == 1);
         send_frame(b, par, stop, 11, coinc);
         model_frame(b, par, stop, coinc);
         wait_cyc(2);
         check($sformatf("rand%0d_frame", i), ps2_read, model_word());
         if (dack) begin
            ack_pulse();
            check($sformatf("rand%0d_ack", i), ps2_read, model_word());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
